// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the data-cache miss sequencer.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_REQ  = 3'd1,
        ST_WB_WAIT = 3'd2,
        ST_RF_REQ  = 3'd3,
        ST_RF_WAIT = 3'd4,
        ST_FILL    = 3'd5,
        ST_COMMIT  = 3'd6
    } ctrl_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORD_OFS = 2;

    // A full-word store overwrites the whole line, so no refill is needed.
    function automatic logic is_word_store(input logic we, input logic [2:0] funct3);
        return we && (funct3 == F3_W);
    endfunction

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// CPU port, cache array and DRAM port bundle for the miss sequencer.
// master = the controller, slave = CPU/array/DRAM environment.
interface dcache_miss_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [2:0]            cpu_funct3;
    logic                  cpu_stall;

    logic                  cache_hit;
    logic                  cache_dirty_en;
    logic [ADDR_WIDTH-1:0] cache_dirty_addr;
    logic [DATA_WIDTH-1:0] cache_dirty_data;
    logic                  cache_commit;
    logic                  cache_we;
    logic [DATA_WIDTH-1:0] cache_new_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_funct3,
        output cpu_stall,
        input  cache_hit, cache_dirty_en, cache_dirty_addr, cache_dirty_data,
        output cache_commit, cache_we, cache_new_data,
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_funct3,
        input  cpu_stall,
        output cache_hit, cache_dirty_en, cache_dirty_addr, cache_dirty_data,
        input  cache_commit, cache_we, cache_new_data,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/dcache_miss_ctrl_sat_counter.sv
// Saturating event counter used for the optional cache statistics.
module sat_counter #(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clear,
    output logic [STAT_WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {STAT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Miss sequencer between the CPU load/store port, a 2-way write-back cache
// array and DRAM: hits complete in the same cycle, misses write back a dirty
// victim, refill one word and replay. Optional statistics counters are built
// when CACHE_STATS_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | serve hits combinationally, capture a miss
// ST_WB_REQ  | present dirty victim write to DRAM until accepted
// ST_WB_WAIT | wait for writeback ack
// ST_RF_REQ  | present refill read to DRAM until accepted
// ST_RF_WAIT | wait for read data, capture it into cache_new_data
// ST_FILL    | install refilled word clean, then replay from IDLE
// ST_COMMIT  | write-allocate a full-word store without fetching
module dcache_miss_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    dcache_miss_ctrl_if.master     bus
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]  stat_hits,
    output logic [STAT_WIDTH-1:0]  stat_misses,
    output logic [STAT_WIDTH-1:0]  stat_wbs
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH-WORD_OFS){1'b1}}, {WORD_OFS{1'b0}}};

    if ((STAT_WIDTH < 1) || (ADDR_WIDTH <= WORD_OFS) || (DATA_WIDTH < 1)) begin : g_bad_params
        $error("dcache_miss_ctrl: illegal parameter combination");
    end

    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [2:0]            lat_funct3;
    logic                  abort_q;
    logic                  abort_now;

    // A miss is abandoned once the CPU drops its request; it stays abandoned.
    assign abort_now = abort_q || !bus.cpu_req;

    // Sequencer state, latched request and registered DRAM/refill outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            lat_addr           <= '0;
            lat_we             <= 1'b0;
            lat_funct3         <= 3'b000;
            abort_q            <= 1'b0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.cache_new_data <= '0;
        end else begin
            abort_q <= (state == ST_IDLE) ? 1'b0 : abort_now;
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_req && !bus.cache_hit) begin
                        lat_addr   <= bus.cpu_addr;
                        lat_we     <= bus.cpu_we;
                        lat_funct3 <= bus.cpu_funct3;
                        if (bus.cache_dirty_en) begin
                            state             <= ST_WB_REQ;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_we        <= 1'b1;
                            bus.mem_addr      <= bus.cache_dirty_addr & ALIGN_MASK;
                            bus.mem_wdata     <= bus.cache_dirty_data;
                        end else if (is_word_store(bus.cpu_we, bus.cpu_funct3)) begin
                            state <= ST_COMMIT;
                        end else begin
                            state             <= ST_RF_REQ;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_we        <= 1'b0;
                            bus.mem_addr      <= bus.cpu_addr & ALIGN_MASK;
                        end
                    end
                end
                ST_WB_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= ST_WB_WAIT;
                    end
                end
                ST_WB_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        if (abort_now) begin
                            state <= ST_IDLE;
                        end else if (is_word_store(lat_we, lat_funct3)) begin
                            state <= ST_COMMIT;
                        end else begin
                            state             <= ST_RF_REQ;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_we        <= 1'b0;
                            bus.mem_addr      <= lat_addr & ALIGN_MASK;
                        end
                    end
                end
                ST_RF_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= ST_RF_WAIT;
                    end
                end
                ST_RF_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        bus.cache_new_data <= bus.mem_rdata;
                        state              <= ST_FILL;
                    end
                end
                ST_FILL:   state <= ST_IDLE;
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Stall and array-update strobes; the array holds still while DRAM is busy.
    always_comb begin
        bus.cpu_stall    = 1'b0;
        bus.cache_commit = 1'b0;
        bus.cache_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cpu_stall    = bus.cpu_req && !bus.cache_hit;
                bus.cache_commit = bus.cpu_req && bus.cache_hit;
                bus.cache_we     = bus.cpu_req && bus.cache_hit && bus.cpu_we;
            end
            ST_WB_REQ, ST_WB_WAIT, ST_RF_REQ, ST_RF_WAIT: begin
                bus.cpu_stall = 1'b1;
            end
            ST_FILL: begin
                bus.cpu_stall    = 1'b1;
                bus.cache_commit = 1'b1;
            end
            ST_COMMIT: begin
                bus.cache_commit = !abort_now;
                bus.cache_we     = !abort_now;
            end
            default: begin
                bus.cpu_stall = 1'b0;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic replay_q;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    // Marks the IDLE cycle right after a fill so the replay hit is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            replay_q <= 1'b0;
        end else begin
            replay_q <= (state == ST_FILL) && !abort_now;
        end
    end

    assign hit_inc  = (state == ST_IDLE) && bus.cpu_req && bus.cache_hit && !replay_q;
    assign miss_inc = (state == ST_IDLE) && bus.cpu_req && !bus.cache_hit;
    assign wb_inc   = (state == ST_WB_REQ) && bus.mem_req_ready;

    sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_stat_hits (
        .clk(clk), .reset(reset), .inc(hit_inc), .clear(1'b0), .count(stat_hits)
    );
    sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_stat_misses (
        .clk(clk), .reset(reset), .inc(miss_inc), .clear(1'b0), .count(stat_misses)
    );
    sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_stat_wbs (
        .clk(clk), .reset(reset), .inc(wb_inc), .clear(1'b0), .count(stat_wbs)
    );
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: a per-cycle vector table for hits and
// the main miss flows, plus hand-written back-pressure, dropped-request and
// reset-in-refill sequences. Statistics are checked when CACHE_STATS_EN is set.
module tb_dcache_miss_ctrl;
    import cache_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dcache_miss_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
    logic [31:0] stat_wbs;
`endif

    dcache_miss_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STAT_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits(stat_hits),
        .stat_misses(stat_misses),
        .stat_wbs(stat_wbs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        req, we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        hit, dirty;
        logic [31:0] vaddr, vdata;
        logic        rdy, rsp;
        logic [31:0] rdata;
        logic        e_stall, e_commit, e_cwe, e_mreq, e_mwe;
        logic [31:0] e_maddr, e_mwdata;
        logic        chk_nd;
        logic [31:0] e_nd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input string nm, input logic req, input logic we, input logic [31:0] addr,
        input logic [2:0] f3, input logic hit, input logic dirty,
        input logic [31:0] vaddr, input logic [31:0] vdata,
        input logic rdy, input logic rsp, input logic [31:0] rdata,
        input logic es, input logic ec, input logic ew, input logic em, input logic emw,
        input logic [31:0] ema, input logic [31:0] emd, input logic cnd, input logic [31:0] e_nd);
        vec_t v;
        v.name = nm; v.req = req; v.we = we; v.addr = addr; v.f3 = f3;
        v.hit = hit; v.dirty = dirty; v.vaddr = vaddr; v.vdata = vdata;
        v.rdy = rdy; v.rsp = rsp; v.rdata = rdata;
        v.e_stall = es; v.e_commit = ec; v.e_cwe = ew; v.e_mreq = em; v.e_mwe = emw;
        v.e_maddr = ema; v.e_mwdata = emd; v.chk_nd = cnd; v.e_nd = e_nd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic req, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic hit, input logic dirty,
                          input logic [31:0] vaddr, input logic [31:0] vdata,
                          input logic rdy, input logic rsp, input logic [31:0] rdata);
        bus.cpu_req          = req;
        bus.cpu_we           = we;
        bus.cpu_addr         = addr;
        bus.cpu_funct3       = f3;
        bus.cache_hit        = hit;
        bus.cache_dirty_en   = dirty;
        bus.cache_dirty_addr = vaddr;
        bus.cache_dirty_data = vdata;
        bus.mem_req_ready    = rdy;
        bus.mem_rsp_valid    = rsp;
        bus.mem_rdata        = rdata;
    endtask

    task automatic chk_core(input string nm, input logic es, input logic ec,
                            input logic ew, input logic em);
        chk({nm, ".stall"},  32'(bus.cpu_stall),     32'(es));
        chk({nm, ".commit"}, 32'(bus.cache_commit),  32'(ec));
        chk({nm, ".cwe"},    32'(bus.cache_we),      32'(ew));
        chk({nm, ".mreq"},   32'(bus.mem_req_valid), 32'(em));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_in(0, 0, 32'h0, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

        //     name            req we addr          f3    hit dty vaddr         vdata         rdy rsp rdata         st cm we mq mw maddr         mwdata        nd e_nd
        vq.push_back(mk("idle",        0, 0, 32'h0000_0000, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("idle_rsp",    0, 0, 32'h0000_0000, F3_W, 0, 0, 32'h0, 32'h0, 1, 1, 32'h55,        0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("ld_hit",      1, 0, 32'h0000_0100, F3_W, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("st_hit_w",    1, 1, 32'h0000_0104, F3_W, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("st_hit_b",    1, 1, 32'h0000_0105, F3_B, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("ld_hit_dty",  1, 0, 32'h0000_0108, F3_H, 1, 1, 32'h900, 32'h1, 1, 0, 32'h0,       0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("cm_idle",     1, 0, 32'h0000_1004, F3_W, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("cm_rfreq",    1, 0, 32'h0000_1004, F3_W, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,         1, 0, 0, 1, 0, 32'h1004, 32'h0, 0, 32'h0));
        vq.push_back(mk("cm_rfwait",   1, 0, 32'h0000_1004, F3_W, 0, 0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("cm_fill",     1, 0, 32'h0000_1004, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF));
        vq.push_back(mk("cm_replay",   1, 0, 32'h0000_1004, F3_W, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("ws_idle",     1, 1, 32'h0000_3000, F3_W, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("ws_commit",   1, 1, 32'h0000_3000, F3_W, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0,         0, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("ws_after",    0, 0, 32'h0000_0000, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("bs_idle",     1, 1, 32'h0000_1003, F3_B, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("bs_rfhold",   1, 1, 32'h0000_1003, F3_B, 0, 0, 32'h0, 32'h0, 0, 1, 32'h77,        1, 0, 0, 1, 0, 32'h1000, 32'h0, 0, 32'h0));
        vq.push_back(mk("bs_rfreq",    1, 1, 32'h0000_1003, F3_B, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,         1, 0, 0, 1, 0, 32'h1000, 32'h0, 0, 32'h0));
        vq.push_back(mk("bs_rfwait",   1, 1, 32'h0000_1003, F3_B, 0, 0, 32'h0, 32'h0, 0, 1, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("bs_fill",     1, 1, 32'h0000_1003, F3_B, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'hCAFE_F00D));
        vq.push_back(mk("bs_replay",   1, 1, 32'h0000_1003, F3_B, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("dl_idle",     1, 0, 32'h0000_4010, F3_W, 0, 1, 32'h2008, 32'h1234_5678, 0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("dl_wbreq",    1, 0, 32'h0000_4010, F3_W, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,         1, 0, 0, 1, 1, 32'h2008, 32'h1234_5678, 0, 32'h0));
        vq.push_back(mk("dl_wbwait",   1, 0, 32'h0000_4010, F3_W, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0,         1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("dl_rfreq",    1, 0, 32'h0000_4010, F3_W, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,         1, 0, 0, 1, 0, 32'h4010, 32'h0, 0, 32'h0));
        vq.push_back(mk("dl_rfwait",   1, 0, 32'h0000_4010, F3_W, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0BAD_F00D, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("dl_fill",     1, 0, 32'h0000_4010, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0BAD_F00D));
        vq.push_back(mk("dl_replay",   1, 0, 32'h0000_4010, F3_W, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        vq.push_back(mk("end_idle",    0, 0, 32'h0000_0000, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0));

        #2;
        chk_core("rst", 0, 0, 0, 0);
        chk("rst.mwe",   32'(bus.mem_we),  32'h0);
        chk("rst.maddr", bus.mem_addr,     32'h0);
        chk("rst.mwd",   bus.mem_wdata,    32'h0);
        chk("rst.nd",    bus.cache_new_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            set_in(vq[i].req, vq[i].we, vq[i].addr, vq[i].f3, vq[i].hit, vq[i].dirty,
                   vq[i].vaddr, vq[i].vdata, vq[i].rdy, vq[i].rsp, vq[i].rdata);
            #2;
            chk_core(vq[i].name, vq[i].e_stall, vq[i].e_commit, vq[i].e_cwe, vq[i].e_mreq);
            if (vq[i].e_mreq) begin
                chk({vq[i].name, ".mwe"},   32'(bus.mem_we), 32'(vq[i].e_mwe));
                chk({vq[i].name, ".maddr"}, bus.mem_addr,    vq[i].e_maddr);
                if (vq[i].e_mwe)
                    chk({vq[i].name, ".mwdata"}, bus.mem_wdata, vq[i].e_mwdata);
            end
            if (vq[i].chk_nd)
                chk({vq[i].name, ".nd"}, bus.cache_new_data, vq[i].e_nd);
        end

`ifdef CACHE_STATS_EN
        chk("stat_hits",   stat_hits,   32'd4);
        chk("stat_misses", stat_misses, 32'd4);
        chk("stat_wbs",    stat_wbs,    32'd1);
`endif

        // Dirty word store under back-pressure: WB payload must hold, then COMMIT.
        @(negedge clk);
        set_in(1, 1, 32'h5000, F3_W, 0, 1, 32'h6004, 32'hA5A5_A5A5, 0, 0, 32'h0);
        #2;
        chk("bp_idle.stall", 32'(bus.cpu_stall), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1, 1, 32'h5000, F3_W, 0, 1, 32'h6F00 + 32'(i), 32'h0, 0, 0, 32'h0);
            #2;
            chk("bp_hold.mreq",  32'(bus.mem_req_valid), 32'h1);
            chk("bp_hold.mwe",   32'(bus.mem_we),        32'h1);
            chk("bp_hold.maddr", bus.mem_addr,           32'h6004);
            chk("bp_hold.wdata", bus.mem_wdata,          32'hA5A5_A5A5);
        end
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        #2;
        chk("bp_accept.mreq", 32'(bus.mem_req_valid), 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            #2;
            chk_core("bp_wbwait", 1, 0, 0, 0);
        end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        #2;
        chk_core("bp_ack", 1, 0, 0, 0);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        #2;
        chk_core("bp_commit", 0, 1, 1, 0);

        // Request dropped during refill: read still completes and FILL still commits.
        @(negedge clk);
        set_in(1, 0, 32'h7000, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #2;
        chk("drop_idle.stall", 32'(bus.cpu_stall), 32'h1);
        @(negedge clk);
        set_in(0, 0, 32'h0, F3_W, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        #2;
        chk("drop_rfreq.mreq",  32'(bus.mem_req_valid), 32'h1);
        chk("drop_rfreq.maddr", bus.mem_addr,           32'h7000);
        @(negedge clk);
        set_in(0, 0, 32'h0, F3_W, 0, 0, 32'h0, 32'h0, 0, 1, 32'h1111_2222);
        #2;
        chk_core("drop_rfwait", 1, 0, 0, 0);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        #2;
        chk_core("drop_fill", 1, 1, 0, 0);
        chk("drop_fill.nd", bus.cache_new_data, 32'h1111_2222);
        @(negedge clk);
        #2;
        chk_core("drop_idle_after", 0, 0, 0, 0);

        // Asynchronous reset while waiting for refill data.
        @(negedge clk);
        set_in(1, 0, 32'h8000, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #2;
        chk_core("rst_rfwait", 1, 0, 0, 0);
        #1;
        reset = 1'b1;
        set_in(0, 0, 32'h0, F3_W, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #1;
        chk_core("rst_mid", 0, 0, 0, 0);
        chk("rst_mid.nd",    bus.cache_new_data, 32'h0);
        chk("rst_mid.maddr", bus.mem_addr,       32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_in(1, 0, 32'h0200, F3_W, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #2;
        chk_core("post_rst_hit", 0, 1, 0, 0);
        @(negedge clk);
        set_in(1, 0, 32'h9002, F3_HU, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #2;
        chk_core("post_rst_miss", 1, 0, 0, 0);
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        #2;
        chk_core("post_rst_rfreq", 1, 0, 0, 1);
        chk("post_rst_rfreq.maddr", bus.mem_addr, 32'h9000);
        @(negedge clk);
        set_in(0, 0, 32'h0, F3_W, 0, 0, 32'h0, 32'h0, 0, 1, 32'h3333_4444);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        #2;
        chk("post_rst_fill.nd", bus.cache_new_data, 32'h3333_4444);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
